// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: access size codes, FSM encoding, clog2 helper.
// Pure declarations; no latency or backpressure of its own.
package mem_resp_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, replicated store word, zero-extended load lane, misalign fault.
// Zero latency; no flow control.
module mem_lane_align
  import mem_resp_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rlane,
  output logic        misalign
);

  always_comb begin
    be       = 4'b0000;
    wword    = '0;
    rlane    = '0;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        rlane = {24'd0, rword[{addr_lo, 3'b000} +: 8]};
      end
      SZ_HALF: begin
        misalign = addr_lo[0];
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        rlane    = {16'd0, (addr_lo[1] ? rword[31:16] : rword[15:0])};
      end
      SZ_WORD: begin
        misalign = (addr_lo != 2'b00);
        be       = 4'b1111;
        wword    = wdata;
        rlane    = rword;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Word-array responder, one access in flight; ready comes WAIT_CYCLES+1 cycles after accept (1 cycle on a fault).
// req is ignored while an access is in progress; MEM_RESP_BUSERR_EN adds an out-of-range bus_err response.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        misalign,
  output logic        bus_err
);

  localparam int AW = clog2(DEPTH_WORDS);

  state_t          state, state_d;
  logic [3:0]      cnt, cnt_d;
  logic            we_q;
  logic [1:0]      size_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            fault_q, berr_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            idle, accept, range_err, commit, lane_fault;
  logic [1:0]      chk_size, chk_lo;
  logic [AW-1:0]   widx;
  logic [3:0]      be;
  logic [31:0]     wword, rlane;

  // The ready cycle is already IDLE, so a req there is accepted (WAIT_CYCLES+2 throughput).
  assign idle     = (state == ST_IDLE);
  assign accept   = idle && req;
  assign chk_size = idle ? size : size_q;
  assign chk_lo   = idle ? addr[1:0] : addr_q[1:0];
  assign widx     = addr_q[AW+1:2];
  assign commit   = (state == ST_RESP) && we_q && !fault_q && !berr_q;

`ifdef MEM_RESP_BUSERR_EN
  assign range_err = (addr >> (AW + 2)) != 32'd0;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];
  assign range_err      = 1'b0;
`endif

  mem_lane_align u_align (
    .size     (chk_size),
    .addr_lo  (chk_lo),
    .wdata    (wdata_q),
    .rword    (mem[widx]),
    .be       (be),
    .wword    (wword),
    .rlane    (rlane),
    .misalign (lane_fault)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (lane_fault || range_err || WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) state_d = ST_RESP;
        else             cnt_d   = cnt - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      fault_q  <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      ready    <= (state == ST_RESP);
      misalign <= (state == ST_RESP) && fault_q;
      bus_err  <= (state == ST_RESP) && berr_q;
      rdata    <= ((state == ST_RESP) && !we_q && !fault_q && !berr_q) ? rlane : '0;
      if (accept)     busy <= 1'b1;
      else if (ready) busy <= 1'b0;
      if (accept) begin
        we_q    <= we;
        size_q  <= size;
        addr_q  <= addr[AW+1:0];
        wdata_q <= wdata;
        fault_q <= lane_fault;
        berr_q  <= range_err && !lane_fault;
      end
    end
  end

  // Storage is never reset; a write landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!reset && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, randomized traffic against a byte-level model,
// plus reset-abort and held-req sequences on a second instance with three wait states.
module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam int DEPTH = 256;
  localparam int W1    = 1;
  localparam int W3    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req, we;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        ready, busy, misalign, bus_err;

  logic        req3, we3;
  logic [1:0]  size3;
  logic [31:0] addr3, wdata3, rdata3;
  logic        ready3, busy3, misalign3, bus_err3;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy), .misalign(misalign), .bus_err(bus_err)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req3), .we(we3), .size(size3), .addr(addr3), .wdata(wdata3),
    .rdata(rdata3), .ready(ready3), .busy(busy3), .misalign(misalign3), .bus_err(bus_err3)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_mem [DEPTH];

  typedef struct {
    string       nm;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        exp_berr;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic void add(input string nm, input logic w, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic m, input logic b,
                              input int l);
    vec_t v;
    v.nm = nm; v.we = w; v.sz = sz; v.addr = a; v.wdata = wd;
    v.exp_rd = rd; v.exp_mis = m; v.exp_berr = b; v.exp_lat = l;
    vecs.push_back(v);
  endfunction

  // Reference: byte-addressed view of a wrapping word array.
  function automatic void model(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic mis, output logic berr, output int lat);
    int idx, off, nbytes;
    idx  = int'((a / 32'd4) % 32'(DEPTH));
    off  = int'(a % 32'd4);
    mis  = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
    berr = 1'b0;
`ifdef MEM_RESP_BUSERR_EN
    if (!mis && a >= 32'(DEPTH * 4)) berr = 1'b1;
`endif
    rd  = '0;
    lat = (mis || berr) ? 1 : W1 + 1;
    if (mis || berr) return;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int b = 0; b < nbytes; b++) begin
      if (w) model_mem[idx][8*(off+b) +: 8] = wd[8*b +: 8];
      else   rd[8*b +: 8] = model_mem[idx][8*(off+b) +: 8];
    end
  endfunction

  // Starts at a negedge; returns at the negedge where ready is seen, with req low.
  task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, input bit junk,
                        output logic [31:0] rd, output logic mis, output logic berr, output int lat);
    bit done;
    req = 1'b1; we = w; size = sz; addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0; done = 1'b0; rd = '0; mis = 1'b0; berr = 1'b0;
    while (!done) begin
      if (junk && lat < exp_lat) begin
        req = 1'b1; we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
      end else begin
        req = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ready) begin
        rd = rdata; mis = misalign; berr = bus_err;
        chk("busy_with_ready", 32'(busy), 32'd1);
        done = 1'b1;
      end else if (lat >= 40) begin
        chk("ready_timeout", 32'(lat), 32'(exp_lat));
        done = 1'b1;
      end
    end
    req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, erd, a, wd;
    logic        m, b, em, eb, w;
    logic [1:0]  sz;
    int          lat, elat, nrdy, first, r1, r2, gap;

    req = 0; we = 0; size = 0; addr = 0; wdata = 0;
    req3 = 0; we3 = 0; size3 = 0; addr3 = 0; wdata3 = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      wd = $urandom;
      model(1'b1, SZ_WORD, 32'(i * 4), wd, erd, em, eb, elat);
      access(1'b1, SZ_WORD, 32'(i * 4), wd, elat, 1'b0, rd, m, b, lat);
      chk("init_lat", 32'(lat), 32'(elat));
    end

    add("w_word_10",   1, SZ_WORD,    32'h10,  32'hDEADBEEF, 32'h0,        0, 0, 2);
    add("r_word_10",   0, SZ_WORD,    32'h10,  32'h0,        32'hDEADBEEF, 0, 0, 2);
    add("w_word_10b",  1, SZ_WORD,    32'h10,  32'h11223344, 32'h0,        0, 0, 2);
    add("w_byte_13",   1, SZ_BYTE,    32'h13,  32'h000000AA, 32'h0,        0, 0, 2);
    add("r_word_10b",  0, SZ_WORD,    32'h10,  32'h0,        32'hAA223344, 0, 0, 2);
    add("r_byte_12",   0, SZ_BYTE,    32'h12,  32'h0,        32'h00000022, 0, 0, 2);
    add("r_half_12",   0, SZ_HALF,    32'h12,  32'h0,        32'h0000AA22, 0, 0, 2);
    add("r_half_21",   0, SZ_HALF,    32'h21,  32'h0,        32'h0,        1, 0, 1);
    add("r_illegal_0", 0, SZ_ILLEGAL, 32'h0,   32'h0,        32'h0,        1, 0, 1);
    add("w_word_0",    1, SZ_WORD,    32'h0,   32'hCAFEF00D, 32'h0,        0, 0, 2);
    add("w_word_2",    1, SZ_WORD,    32'h2,   32'hFFFFFFFF, 32'h0,        1, 0, 1);
    add("r_word_0",    0, SZ_WORD,    32'h0,   32'h0,        32'hCAFEF00D, 0, 0, 2);
    add("w_word_14",   1, SZ_WORD,    32'h14,  32'h55667788, 32'h0,        0, 0, 2);
    add("w_half_16",   1, SZ_HALF,    32'h16,  32'h0000BEEF, 32'h0,        0, 0, 2);
    add("r_word_14",   0, SZ_WORD,    32'h14,  32'h0,        32'hBEEF7788, 0, 0, 2);
    add("r_byte_15",   0, SZ_BYTE,    32'h15,  32'h0,        32'h00000077, 0, 0, 2);
    add("r_half_401",  0, SZ_HALF,    32'h401, 32'h0,        32'h0,        1, 0, 1);
`ifdef MEM_RESP_BUSERR_EN
    add("r_word_400",  0, SZ_WORD,    32'h400, 32'h0,        32'h0,        0, 1, 1);
`else
    add("r_word_400",  0, SZ_WORD,    32'h400, 32'h0,        32'hCAFEF00D, 0, 0, 2);
`endif

    foreach (vecs[i]) begin
      model(vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].wdata, erd, em, eb, elat);
      access(vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].wdata, vecs[i].exp_lat, 1'b0, rd, m, b, lat);
      chk({vecs[i].nm, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].nm, "_misalign"}, 32'(m), 32'(vecs[i].exp_mis));
      chk({vecs[i].nm, "_bus_err"}, 32'(b), 32'(vecs[i].exp_berr));
      chk({vecs[i].nm, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
    end

    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? SZ_ILLEGAL : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 4))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(1016, 1031));
        default: a = 32'($urandom_range(0, 1023));
      endcase
      wd = $urandom;
      model(w, sz, a, wd, erd, em, eb, elat);
      access(w, sz, a, wd, elat, 1'($urandom), rd, m, b, lat);
      chk("rand_rdata", rd, erd);
      chk("rand_misalign", 32'(m), 32'(em));
      chk("rand_bus_err", 32'(b), 32'(eb));
      chk("rand_lat", 32'(lat), 32'(elat));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
        repeat (gap - 1) @(negedge clk);
      end
    end

    // Reset while the write of 0x40 sits in WAIT.
    req = 1; we = 1; size = SZ_WORD; addr = 32'h40; wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req = 0; reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("rstw_ready", 32'(ready), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_rdata", rdata, 32'd0);
    chk("rstw_misalign", 32'(misalign), 32'd0);
    chk("rstw_bus_err", 32'(bus_err), 32'd0);
    nrdy = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready) nrdy++;
    end
    chk("rstw_no_ready", 32'(nrdy), 32'd0);

    // Reset landing on the RESP edge of the same write.
    req = 1; we = 1; size = SZ_WORD; addr = 32'h40; wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("rstr_ready", 32'(ready), 32'd0);
    chk("rstr_busy", 32'(busy), 32'd0);
    nrdy = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready) nrdy++;
    end
    chk("rstr_no_ready", 32'(nrdy), 32'd0);

    model(1'b0, SZ_WORD, 32'h40, 32'h0, erd, em, eb, elat);
    access(1'b0, SZ_WORD, 32'h40, 32'h0, elat, 1'b0, rd, m, b, lat);
    chk("rst_old_0x40", rd, erd);

    // Held req on the three-wait-state instance.
    @(negedge clk);
    we3 = 1; size3 = SZ_WORD; addr3 = 32'h8; wdata3 = 32'h5A5A5A5A; req3 = 1;
    @(posedge clk);
    nrdy = 0; first = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready3) begin
        nrdy++;
        if (first == 0) begin
          first = c;
          chk("hold_rdata", rdata3, 32'd0);
          chk("hold_misalign", 32'(misalign3), 32'd0);
          chk("hold_bus_err", 32'(bus_err3), 32'd0);
        end
        req3 = 0;
      end
    end
    chk("hold_ready_count", 32'(nrdy), 32'd1);
    chk("hold_ready_lat", 32'(first), 32'(W3 + 1));

    req3 = 1;
    @(posedge clk);
    r1 = 0; r2 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready3) begin
        if (r1 == 0) r1 = c;
        else if (r2 == 0) r2 = c;
      end
    end
    req3 = 0;
    chk("b2b_first_lat", 32'(r1), 32'(W3 + 1));
    chk("b2b_period", 32'(r2 - r1), 32'(W3 + 2));
    repeat (10) @(negedge clk);
    chk("b2b_drained", 32'(busy3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU.
- Answers the single-outstanding read/write requests issued by the control unit and datapath: instruction fetch, load and store.
- Holds a word-organised storage array and inserts a programmable number of wait states.
- Returns read data, a ready pulse and an alignment-fault flag. The control unit uses the fault flag to branch to its exception states.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; power of two.
- WAIT_CYCLES, 1, wait states between accept and response; legal range 0..15.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request strobe from control unit; sampled only in IDLE.
- we  input  1  1 = write (store), 0 = read.
- size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- addr  input  32  byte address.
- wdata  input  32  store data, right-justified for byte/half.
- rdata  output  32  load data, zero-extended, right-justified; valid only while ready=1.
- ready  output  1  one-cycle response pulse.
- busy  output  1  high from accept until the cycle after ready.
- misalign  output  1  fault qualifier, valid with ready.
- bus_err  output  1  out-of-range qualifier, valid with ready (see Optional Feature).

Behaviour:
- Reset: state=IDLE, wait counter=0, rdata=0, ready=0, busy=0, misalign=0, bus_err=0.
- Reset does not clear array contents.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req=1 latches we, size, addr and wdata; busy=1 next cycle.
  - Fault check at accept:
    - size=11 is a fault.
    - half with addr[0]=1 is a fault.
    - word with addr[1:0]!=0 is a fault.
  - Fault: go straight to RESP.
  - No fault, WAIT_CYCLES=0: go to RESP.
  - No fault, WAIT_CYCLES>0: go to WAIT with counter=WAIT_CYCLES-1.
- WAIT: decrement counter each cycle; at counter=0, go to RESP.
- Latency: ready asserts exactly WAIT_CYCLES+1 cycles after the accepting edge.
- RESP, registered outputs, ready=1 for one cycle:
  - Read: rdata = selected lane, zero-extended.
    - byte: lane addr[1:0], little-endian; byte 0 = bits 7:0.
    - half: lane addr[1].
  - Write: the array word is updated on the RESP edge, byte lanes only; other bytes are preserved. rdata=0.
  - Fault: misalign=1, rdata=0, no array write.
  - Next state: IDLE. busy drops together with ready.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap.
- req while busy: ignored; not queued, no error.
- A new req in the cycle after ready is accepted normally, so back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Latched inputs are used throughout; changes to addr/wdata after accept have no effect.
- Reset mid-operation: returns to IDLE immediately, no ready pulse. A pending write is dropped; a write committed in RESP on the same edge as reset is also dropped.

Optional Feature:
- Macro: MEM_RESP_BUSERR_EN.
- Defined:
  - addr >= DEPTH_WORDS*4 is checked at accept, after the misalign check.
  - If out of range, go to RESP directly: ready=1, bus_err=1, rdata=0, no write.
  - If misalign and range faults coincide, only misalign=1.
- Undefined: addresses wrap as above; bus_err tied 0.

Decomposition:
- Package mem_resp_pkg holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL;
  - FSM state encoding (2 bits);
  - clog2 helper.
- Sub-module mem_lane_align (combinational), given size, addr[1:0] and wdata:
  - produces the 4-bit byte-enable mask and lane-shifted write word;
  - extracts and zero-extends the read lane;
  - raises the misalign fault.

Test Plan:
- Word write then read, WAIT_CYCLES=1: write 0xDEADBEEF to 0x10, then read 0x10 -> ready on the 2nd cycle after each accept; rdata=0xDEADBEEF, misalign=0.
- Byte lanes: write byte 0xAA to 0x13 over word 0x11223344 -> word reads 0xAA223344; byte read at 0x12 -> 0x00000022.
- Faults:
  - half read at 0x21 -> ready next cycle with misalign=1, rdata=0;
  - size=11 at 0x0 -> misalign=1;
  - word write at 0x2 -> misalign=1 and array unchanged.
- req held high during WAIT with WAIT_CYCLES=3 -> exactly one ready (4 cycles after accept); the second req is accepted only in IDLE.
- Reset asserted in WAIT of a write of 0x12345678 to 0x40 -> no ready; a later read of 0x40 returns the old value; all outputs 0 the cycle after reset.
- DEPTH_WORDS=256, read 0x400:
  - without macro -> data of word 0;
  - with MEM_RESP_BUSERR_EN -> bus_err=1, rdata=0.
